// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO; bytes accepted over valid/ready,
// serialized LSB-first with one start and one stop bit.
//
// state | meaning
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); chains straight into START if more bytes wait
module uart_tx_fifo #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 16,
  localparam int DIVISOR   = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE,
  localparam int AW        = $clog2(FIFO_DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic          clk_pin,
  input  logic          rst_pin,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          txd_pin,
  output logic          tx_busy,
  output logic [CW-1:0] fifo_count,
  output logic          overflow
);

  localparam int BW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIVISOR - 1);
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [BW-1:0]   baud, baud_n;
  logic [2:0]      bit_idx, bit_n;
  logic [9:0]      shreg, shreg_n;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_n;
  logic [7:0]      mem [FIFO_DEPTH];
  logic            push, pop, empty, baud_wrap;

  assign tx_ready  = (fifo_count != FULL);
  assign push      = tx_valid && tx_ready;
  assign empty     = (fifo_count == '0);
  assign baud_wrap = (baud == BAUD_LAST);
  // Bit 0 of the frame shift register is the line itself, so txd is a flop output.
  assign txd_pin   = shreg[0];

  always_ff @(posedge clk_pin) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  always_comb begin
    state_n = state;
    baud_n  = baud;
    bit_n   = bit_idx;
    shreg_n = shreg;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        shreg_n = '1;
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = {1'b1, mem[rd_ptr], 1'b0};
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (baud_wrap) begin
          baud_n  = '0;
          bit_n   = '0;
          shreg_n = {1'b1, shreg[9:1]};
          state_n = DATA;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud_wrap) begin
          baud_n  = '0;
          shreg_n = {1'b1, shreg[9:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP: begin
        if (baud_wrap) begin
          baud_n = '0;
          if (!empty) begin
            pop     = 1'b1;
            shreg_n = {1'b1, mem[rd_ptr], 1'b0};
            state_n = START;
          end else begin
            shreg_n = '1;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    count_n = fifo_count + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk_pin or negedge rst_pin) begin
    if (!rst_pin) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shreg      <= '1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      tx_busy    <= 1'b0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_idx    <= bit_n;
      shreg      <= shreg_n;
      fifo_count <= count_n;
      tx_busy    <= (state_n != IDLE) || (count_n != '0);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (tx_valid && !tx_ready) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: DIVISOR=10, FIFO_DEPTH=4; the line is logged
// every cycle and frames are decoded by a mid-bit sampling receiver.
module tb_uart_tx_fifo;
  localparam int LOGN = 8192;

  logic       clk_pin = 1'b0;
  logic       rst_pin;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       txd_pin;
  logic       tx_busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic txd_log  [LOGN];
  logic busy_log [LOGN];
  logic [7:0] led;

  uart_tx_fifo #(.CLOCK_RATE(1_000_000), .BAUD_RATE(100_000), .FIFO_DEPTH(4)) dut (
    .clk_pin(clk_pin), .rst_pin(rst_pin), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd_pin(txd_pin), .tx_busy(tx_busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk_pin = ~clk_pin;
  always @(posedge clk_pin) cyc <= cyc + 1;
  // Entry e holds the line as it stands after posedge number e.
  always @(negedge clk_pin) begin
    if (cyc < LOGN) begin
      txd_log[cyc]  = txd_pin;
      busy_log[cyc] = tx_busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int slot = k / 10;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  function automatic logic [7:0] decode_at(input int s);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = txd_log[s + 15 + 10 * i];
    return d;
  endfunction

  task automatic push_byte(input logic [7:0] b, output int e);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk_pin); #1;
    e = cyc;
  endtask

  task automatic wait_to(input int e);
    while (cyc < e) begin
      @(posedge clk_pin); #1;
    end
  endtask

  task automatic test_reset();
    rst_pin = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    #2 rst_pin = 1'b0;
    #1;
    n_checks++; if (txd_pin !== 1'b1) begin n_fail++; $display("FAIL rst_txd: got %b want 1", txd_pin); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", tx_busy); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", tx_ready); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", overflow); end
    @(posedge clk_pin); #1;
    @(posedge clk_pin); #1;
    rst_pin = 1'b1;
    repeat (3) begin @(posedge clk_pin); #1; end
    n_checks++; if (txd_pin !== 1'b1) begin n_fail++; $display("FAIL post_rst_txd: got %b want 1", txd_pin); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy: got %b want 0", tx_busy); end
  endtask

  task automatic test_single();
    int n;
    push_byte(8'hA5, n);
    tx_valid = 1'b0;
    n_checks++; if (tx_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_after_push: got %b want 1", tx_busy); end
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    wait_to(n + 102);
    for (int k = 0; k < 100; k++) begin
      n_checks++;
      if (txd_log[n+1+k] !== exp_bit(8'hA5, k)) begin
        n_fail++; $display("FAIL single_wave[%0d]: got %b want %b", k, txd_log[n+1+k], exp_bit(8'hA5, k));
      end
    end
    n_checks++; if (busy_log[n+100] !== 1'b1) begin n_fail++; $display("FAIL single_busy_last: got %b want 1", busy_log[n+100]); end
    n_checks++; if (busy_log[n+101] !== 1'b0) begin n_fail++; $display("FAIL single_busy_drop: got %b want 0", busy_log[n+101]); end
    n_checks++; if (txd_log[n+101] !== 1'b1) begin n_fail++; $display("FAIL single_idle: got %b want 1", txd_log[n+101]); end
    n_checks++; if (decode_at(n+1) !== 8'hA5) begin n_fail++; $display("FAIL single_decode: got %h want a5", decode_at(n+1)); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [3] = '{8'h00, 8'hFF, 8'h55};
    int n, e;
    push_byte(b[0], n);
    push_byte(b[1], e);
    push_byte(b[2], e);
    tx_valid = 1'b0;
    wait_to(n + 302);
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 100; k++) begin
        n_checks++;
        if (txd_log[n+1+100*i+k] !== exp_bit(b[i], k)) begin
          n_fail++; $display("FAIL b2b_wave[%0d][%0d]: got %b want %b", i, k, txd_log[n+1+100*i+k], exp_bit(b[i], k));
        end
      end
      n_checks++;
      if (decode_at(n+1+100*i) !== b[i]) begin
        n_fail++; $display("FAIL b2b_decode[%0d]: got %h want %h", i, decode_at(n+1+100*i), b[i]);
      end
    end
    n_checks++; if (busy_log[n+301] !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b want 0", busy_log[n+301]); end
  endtask

  task automatic test_overflow();
    logic [7:0] b [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int n, e;
    for (int i = 0; i < 6; i++) begin
      push_byte(b[i], e);
      if (i == 0) n = e;
      if (i == 4) begin
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count_full: got %0d want 4", fifo_count); end
        n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_full: got %b want 0", tx_ready); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
    end
    tx_valid = 1'b0;
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", overflow); end
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count_kept: got %0d want 4", fifo_count); end
    wait_to(n + 502);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (txd_log[n+1+100*i] !== 1'b0) begin n_fail++; $display("FAIL ovf_start[%0d]: got %b want 0", i, txd_log[n+1+100*i]); end
      n_checks++;
      if (decode_at(n+1+100*i) !== b[i]) begin
        n_fail++; $display("FAIL ovf_decode[%0d]: got %h want %h", i, decode_at(n+1+100*i), b[i]);
      end
    end
    n_checks++; if (busy_log[n+501] !== 1'b0) begin n_fail++; $display("FAIL ovf_only5_busy: got %b want 0", busy_log[n+501]); end
    n_checks++; if (txd_log[n+501] !== 1'b1) begin n_fail++; $display("FAIL ovf_only5_txd: got %b want 1", txd_log[n+501]); end
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] b [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB5};
    int n, e;
    for (int i = 0; i < 5; i++) begin
      push_byte(b[i], e);
      if (i == 0) n = e;
    end
    tx_valid = 1'b0;
    wait_to(n + 100);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL sim_pre_count: got %0d want 4", fifo_count); end
    n_checks++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL sim_pre_ready: got %b want 0", tx_ready); end
    push_byte(8'hEE, e);
    n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL sim_reject_count: got %0d want 3", fifo_count); end
    n_checks++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL sim_reject_ready: got %b want 1", tx_ready); end
    push_byte(b[5], e);
    tx_valid = 1'b0;
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL sim_accept_count: got %0d want 4", fifo_count); end
    wait_to(n + 602);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (decode_at(n+1+100*i) !== b[i]) begin
        n_fail++; $display("FAIL sim_decode[%0d]: got %h want %h", i, decode_at(n+1+100*i), b[i]);
      end
    end
    n_checks++; if (busy_log[n+601] !== 1'b0) begin n_fail++; $display("FAIL sim_busy_end: got %b want 0", busy_log[n+601]); end
  endtask

  task automatic test_reset_mid_frame();
    int n, e;
    push_byte(8'h00, n);
    push_byte(8'h0F, e);
    tx_valid = 1'b0;
    wait_to(n + 20);
    n_checks++; if (txd_pin !== 1'b0) begin n_fail++; $display("FAIL mid_pre_txd: got %b want 0", txd_pin); end
    #2 rst_pin = 1'b0;
    #1;
    n_checks++; if (txd_pin !== 1'b1) begin n_fail++; $display("FAIL mid_rst_txd: got %b want 1", txd_pin); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", fifo_count); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_overflow: got %b want 0", overflow); end
    n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", tx_busy); end
    @(posedge clk_pin); #1;
    @(posedge clk_pin); #1;
    rst_pin = 1'b1;
    e = cyc;
    wait_to(e + 41);
    for (int k = 0; k <= 40; k++) begin
      n_checks++;
      if (txd_log[e+k] !== 1'b1 || busy_log[e+k] !== 1'b0) begin
        n_fail++; $display("FAIL mid_residual[%0d]: txd %b busy %b want 1 0", k, txd_log[e+k], busy_log[e+k]);
      end
    end
  endtask

  task automatic test_integration();
    int n, s;
    bit found;
    push_byte(8'h3C, n);
    tx_valid = 1'b0;
    wait_to(n + 115);
    found = 1'b0;
    s = 0;
    for (int i = n; i <= n + 20; i++) begin
      if (!found && txd_log[i] === 1'b0) begin found = 1'b1; s = i; end
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL int_start: no start bit within 20 cycles");
    end else begin
      led = decode_at(s);
      n_checks++; if (s !== n + 1) begin n_fail++; $display("FAIL int_latency: got edge %0d want %0d", s, n + 1); end
      n_checks++; if (led !== 8'h3C) begin n_fail++; $display("FAIL int_led: got %h want 3c", led); end
      n_checks++; if (txd_log[s+95] !== 1'b1) begin n_fail++; $display("FAIL int_stop: got %b want 1", txd_log[s+95]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_simultaneous();
    test_reset_mid_frame();
    test_integration();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
